// File: rtl/decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter for eight requesters. The grant is driven as an
// active-low one-hot vector, in the style of a decoder output. A rotating
// pointer marks the requester with the highest priority. After each release
// the pointer moves one place past the owner that released.
//
// Every release is followed by at least one IDLE cycle, and requests are only
// sampled in IDLE. Requests from other requesters during a grant are dropped,
// not queued.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//    When defined, an 8-bit hold counter is added. An owner that keeps the
//    grant for MAX_HOLD cycles is forced to release, and timeout pulses for
//    one cycle. When undefined, there is no counter and timeout is tied low.
//
// Parameters:
//    MAX_HOLD   - grant cycles before forced release (1..255); only has an
//                 effect with ARB_TIMEOUT_EN.
//
// Ports:
//    clk        - clock, rising edge
//    rst        - asynchronous active-high reset
//    en         - enables new grants; dropping it releases the current owner
//    req[7:0]   - per-requester request lines
//    done       - single-cycle release strobe from the current owner
//    grant_n    - registered active-low one-hot grant (8'hFF = none)
//    grant_idx  - registered binary index of the owner (0 when idle)
//    busy       - registered, high while a grant is held
//    timeout    - registered single-cycle pulse on forced release
// ---------------------------------------------------------------------------
module decoder_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant_n,
   output logic [2:0] grant_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      Idle  = 1'b0,
      Grant = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] grant_n_q, grant_n_d;
   logic [2:0] idx_q, idx_d;
   logic       busy_q, busy_d;

   logic       found;
   logic [2:0] winner;
   logic       releaseNormal;
   logic       holdExpired;
   logic       doGrant;
   logic       doRelease;

   // An out-of-range hold limit would make the counter compare meaningless,
   // so stop elaboration instead of building a broken arbiter.
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : gBadMaxHold
      $error("decoder_rr_arbiter: MAX_HOLD must be in 1..255");
   end

   // Search for the first request, starting at the pointer and wrapping.
   // The 3-bit addition gives the modulo-8 wrap without extra logic.
   always_comb begin
      logic [2:0] cand;
      found  = 1'b0;
      winner = ptr_q;
      cand   = ptr_q;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Causes of an ordinary release. Any of these also suppresses the timeout
   // pulse when it falls on the same edge as the hold limit.
   assign releaseNormal = done | ~req[idx_q] | ~en;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] holdCnt_q, holdCnt_d;
   logic       timeout_q, timeout_d;

   // The counter holds the number of grant cycles already completed. The
   // limit is therefore reached on the edge that ends cycle MAX_HOLD.
   assign holdExpired = ({1'b0, holdCnt_q} + 9'd1) == 9'(MAX_HOLD);

   // Clear on entry to GRANT, then count every cycle the grant is held.
   always_comb begin
      holdCnt_d = holdCnt_q;
      if (doGrant) begin
         holdCnt_d = 8'd0;
      end else if (state_q == Grant) begin
         holdCnt_d = holdCnt_q + 8'd1;
      end
   end

   // A forced release pulses timeout, unless an ordinary release happens on
   // the same edge.
   always_comb begin
      timeout_d = 1'b0;
      if (doRelease && holdExpired && !releaseNormal) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdCnt_q <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         holdCnt_q <= holdCnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign holdExpired = 1'b0;
   assign timeout     = 1'b0;
`endif

   assign doGrant   = (state_q == Idle)  && en && found;
   assign doRelease = (state_q == Grant) && (releaseNormal || holdExpired);

   // State register. The registered outputs sit here too, so that reset
   // clears them asynchronously together with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= Idle;
         ptr_q     <= 3'd0;
         grant_n_q <= 8'hFF;
         idx_q     <= 3'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_n_q <= grant_n_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic. On release the pointer moves one place past the
   // owner that is leaving.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (doGrant) begin
         state_d = Grant;
      end else if (doRelease) begin
         state_d = Idle;
         ptr_d   = idx_q + 3'd1;
      end
   end

   // Output logic. This computes the next values of the registered outputs.
   // grant_n is the inverted decode of the same index loaded into grant_idx,
   // so the two always agree.
   always_comb begin
      grant_n_d = grant_n_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      if (doGrant) begin
         grant_n_d = ~(8'b1 << winner);
         idx_d     = winner;
         busy_d    = 1'b1;
      end else if (doRelease) begin
         grant_n_d = 8'hFF;
         idx_d     = 3'd0;
         busy_d    = 1'b0;
      end
   end

   assign grant_n   = grant_n_q;
   assign grant_idx = idx_q;
   assign busy      = busy_q;

endmodule
